serial_rx: RTL and testbench
============================

SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of rx input synchronizer flops, minimum 2.
REQ-002 clk_115200hz  in  1  bit-rate clock, one edge per serial bit, rising-edge active.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 rx  in  1  serial line, idle high; frame is start(0), 8 data bits, stop(1).
REQ-005 ack  in  1  consumer acknowledge; clears valid and overrun.
REQ-006 data  out  8  received byte, declared [0:7]; first serial bit after start lands in data[7], last in data[0].
REQ-007 valid  out  1  level; high while data holds an unacknowledged byte.
REQ-008 frame_err  out  1  one-cycle pulse on a bad stop bit.
REQ-009 overrun  out  1  sticky; a completed byte overwrote an unacknowledged one.
REQ-010 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-011 rx SHALL pass through SYNC_STAGES flops; the FSM SHALL use only the last stage (rx_s).
REQ-012 FSM states SHALL be IDLE, DATA, STOP, BREAK.
REQ-013 IDLE: rx_s=0 -> DATA with bit counter 7; otherwise stay.
REQ-014 DATA: each edge store rx_s into shift register index counter, decrement; after index 0 is stored -> STOP (exactly 8 DATA cycles).
REQ-015 STOP: rx_s=1 -> load data from shift register, valid=1, -> IDLE.
REQ-016 STOP: rx_s=0 -> frame_err=1 for that cycle, discard byte, data/valid unchanged, -> BREAK.
REQ-017 BREAK: stay while rx_s=0; rx_s=1 -> IDLE.
REQ-018 Latency: if the first rising edge sampling rx=0 of the start bit is t0, the FSM SHALL leave IDLE at t0+SYNC_STAGES and valid SHALL rise at edge t0+SYNC_STAGES+9.
REQ-019 Back-to-back frames: a start bit sampled in the cycle after STOP SHALL be accepted with no idle gap required.
REQ-020 ack with valid=1 and no completion that edge: valid->0, overrun->0.
REQ-021 ack with valid=0: ignored.
REQ-022 Completion with valid=1 and ack=0: data overwritten with new byte, valid stays 1, overrun->1.
REQ-023 Completion and ack on the same edge: new byte loaded, valid stays 1, overrun->0.
REQ-024 Overrun SHALL remain set until an ack that does not coincide with an overrunning completion.
REQ-025 busy SHALL equal (state != IDLE), registered with the state.

Reset
REQ-026 On reset: state IDLE, counter 7, shift register 0, data 8'h00, valid 0, overrun 0, frame_err 0, busy 0, all synchronizer flops 1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err; reception resumes at the next start bit after release.

Structure
REQ-028 State encodings (IDLE=0, DATA=1, STOP=2, BREAK=3) and DATA_BITS=8 SHALL live in the shared uart package, which is also used by the transmitter.
REQ-029 The synchronizer SHALL be a sub-module rx_sync (parameter SYNC_STAGES, reset value 1); all other logic SHALL reside in serial_rx.

Verification
REQ-030 Drive rx 0,1,0,1,0,0,1,0,1,1 one bit per clock -> data=8'hA5, valid rises at t0+11, frame_err never pulses.
REQ-031 Two back-to-back frames 8'h3C then 8'hFF, no ack -> data=8'hFF, valid=1, overrun=1; a single ack -> valid=0, overrun=0.
REQ-032 Frame 8'h55 with stop bit 0, line held low 5 more cycles, then high -> one frame_err pulse, busy stays high until rx_s=1, data/valid unchanged; the next frame 8'h0F is received correctly.
REQ-033 ack asserted on the completion edge of frame 8'h81 while valid=1 -> data=8'h81, valid=1, overrun=0.
REQ-034 Assert reset after the 4th data bit of frame 8'hC3 -> all outputs at reset values, no valid; the following frame 8'h7E yields data=8'h7E.
REQ-035 Loopback: transmitter output connected to rx, transmit 8'h00, 8'hFF, 8'hA5 -> each received byte equals the transmitted byte, index for index.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame geometry and small
// helpers used by both the receiver and the transmitter.
`timescale 1ns/1ps
package uart_pkg;

  // Payload bits per frame and the width of the bit-index counter.
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned CNT_W     = 3;

  typedef logic [1:0]       state_t;
  typedef logic [CNT_W-1:0] bit_cnt_t;

  // FSM state encodings (legacy-compatible constants).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_STOP  = 2'd2;
  localparam logic [1:0] ST_BREAK = 2'd3;

  // Bit counter endpoints: reception starts at the highest index.
  localparam logic [CNT_W-1:0] CNT_LAST = 3'd7;
  localparam logic [CNT_W-1:0] CNT_ZERO = 3'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = 3'd1;

  // True whenever the given state is not IDLE.
  function automatic logic state_is_busy(input logic [1:0] st);
    return (st != ST_IDLE);
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line. Flops reset to
// the idle (high) line level so no false start bit is seen after reset.
`timescale 1ns/1ps
module rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_115200hz,
  input  logic reset,
  input  logic rx,
  output logic rx_s
);

  logic [SYNC_STAGES-1:0] sync_r;

  // Shift the raw line through the synchronizer chain.
  always_ff @(posedge clk_115200hz or posedge reset) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/serial_rx.sv
// Serial receiver: one clock edge per bit, frame = start(0), 8 data bits,
// stop(1). Holds the last good byte with a valid/ack handshake, flags
// overwritten bytes as overrun and pulses frame_err on a bad stop bit.
`timescale 1ns/1ps
module serial_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_115200hz,
  input  logic       reset,
  input  logic       rx,
  input  logic       ack,
  output logic [0:7] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  logic                 rx_s;
  logic [1:0]           state_r;
  logic [1:0]           state_nxt_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [0:DATA_BITS-1] shift_r;
  logic [0:DATA_BITS-1] data_r;
  logic                 valid_r;
  logic                 overrun_r;
  logic                 frame_err_r;
  logic                 busy_r;
  logic                 start_s;
  logic                 complete_s;
  logic                 bad_stop_s;

  rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx_sync (
    .clk_115200hz (clk_115200hz),
    .reset        (reset),
    .rx           (rx),
    .rx_s         (rx_s)
  );

  // Next-state decode plus the start / completion / bad-stop events.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    complete_s  = 1'b0;
    bad_stop_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rx_s) begin
          state_nxt_s = ST_DATA;
          start_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (rx_s) begin
          state_nxt_s = ST_IDLE;
          complete_s  = 1'b1;
        end else begin
          state_nxt_s = ST_BREAK;
          bad_stop_s  = 1'b1;
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BREAK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and busy flag, which is registered alongside the state.
  always_ff @(posedge clk_115200hz or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= state_is_busy(state_nxt_s);
    end
  end

  // Bit counter and shift register: each DATA edge stores rx_s at the
  // current index (first bit at index 7) and counts down.
  always_ff @(posedge clk_115200hz or posedge reset) begin
    if (reset) begin
      cnt_r   <= CNT_LAST;
      shift_r <= {DATA_BITS{1'b0}};
    end else if (start_s) begin
      cnt_r   <= CNT_LAST;
      shift_r <= shift_r;
    end else if (state_r == ST_DATA) begin
      cnt_r          <= cnt_r - CNT_ONE;
      shift_r[cnt_r] <= rx_s;
    end else begin
      cnt_r   <= cnt_r;
      shift_r <= shift_r;
    end
  end

  // Output byte, valid/overrun handshake and the one-cycle frame error.
  // A completion always wins over an ack for valid; an ack on the same
  // edge only decides whether the overwrite counts as an overrun.
  always_ff @(posedge clk_115200hz or posedge reset) begin
    if (reset) begin
      data_r      <= 8'h00;
      valid_r     <= 1'b0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= bad_stop_s;
      if (complete_s) begin
        data_r  <= shift_r;
        valid_r <= 1'b1;
        if (valid_r && !ack) begin
          overrun_r <= 1'b1;
        end else if (valid_r && ack) begin
          overrun_r <= 1'b0;
        end else begin
          overrun_r <= overrun_r;
        end
      end else if (ack && valid_r) begin
        data_r    <= data_r;
        valid_r   <= 1'b0;
        overrun_r <= 1'b0;
      end else begin
        data_r    <= data_r;
        valid_r   <= valid_r;
        overrun_r <= overrun_r;
      end
    end
  end

  assign data      = data_r;
  assign valid     = valid_r;
  assign overrun   = overrun_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx: table of frames plus hand-written
// sequences for latency, overrun, break, ack-on-completion, mid-frame
// reset and a loopback from a bench-side transmitter. Bytes expected to
// raise valid are queued on a scoreboard and popped when valid rises.
`timescale 1ns/1ps
module tb_serial_rx;
  import uart_pkg::*;

  localparam int SYNC = 2;

  typedef struct {
    logic [7:0] tx_byte;
    logic [7:0] exp_data;
  } vec_t;

  logic       clk_115200hz = 1'b0;
  logic       reset        = 1'b1;
  logic       ack          = 1'b0;
  logic       rx_drv       = 1'b1;
  logic       tx_line      = 1'b1;
  logic       loop_en      = 1'b0;
  logic       rx;
  logic [0:7] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total    = 0;
  int bad      = 0;
  int fe_count = 0;

  logic [7:0]           sb_q[$];
  logic [7:0]           tx_q[$];
  logic [7:0]           mon_exp;
  logic                 mon_vq     = 1'b0;
  logic                 tx_active  = 1'b0;
  logic [DATA_BITS+1:0] tx_frame;
  int                   tx_idx     = 0;
  vec_t                 vecs[9];

  assign rx = loop_en ? tx_line : rx_drv;

  always #5 clk_115200hz = ~clk_115200hz;

  serial_rx #(.SYNC_STAGES(SYNC)) dut (
    .clk_115200hz (clk_115200hz),
    .reset        (reset),
    .rx           (rx),
    .ack          (ack),
    .data         (data),
    .valid        (valid),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .busy         (busy)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Start bit, 8 data bits LSB first, stop bit; returns right after the
  // stop bit has been driven so a following frame can start with no gap.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk_115200hz); rx_drv = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) begin
      @(negedge clk_115200hz); rx_drv = b[i];
    end
    @(negedge clk_115200hz); rx_drv = stop_bit;
  endtask

  task automatic ack_pulse();
    @(negedge clk_115200hz); ack = 1'b1;
    @(negedge clk_115200hz); ack = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (valid !== 1'b1 && n < 60) begin
      @(negedge clk_115200hz);
      n++;
    end
    total++;
    if (valid !== 1'b1) begin
      bad++;
      $display("FAIL %s: valid still %b after %0d cycles, want 1", name, valid, n);
    end
  endtask

  initial begin
    logic [9:0] fr;

    vecs[0] = '{8'h00, 8'h00};
    vecs[1] = '{8'hFF, 8'hFF};
    vecs[2] = '{8'h3C, 8'h3C};
    vecs[3] = '{8'h81, 8'h81};
    vecs[4] = '{8'h55, 8'h55};
    vecs[5] = '{8'h0F, 8'h0F};
    vecs[6] = '{8'h7E, 8'h7E};
    vecs[7] = '{8'h01, 8'h01};
    vecs[8] = '{8'h80, 8'h80};

    fork
      // Scoreboard monitor: pop an expected byte on every rising valid.
      forever begin
        @(negedge clk_115200hz);
        if (frame_err === 1'b1) fe_count++;
        if (valid === 1'b1 && mon_vq == 1'b0) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: valid rose with data %h, none expected", data);
          end else begin
            mon_exp = sb_q.pop_front();
            chk("sb_data", data, mon_exp);
          end
        end
        mon_vq = valid;
      end
      // Bench transmitter for loopback: frames bytes from tx_q onto tx_line.
      forever begin
        @(negedge clk_115200hz);
        if (!tx_active && tx_q.size() > 0) begin
          tx_frame  = {1'b1, tx_q.pop_front(), 1'b0};
          tx_idx    = 0;
          tx_active = 1'b1;
        end
        if (tx_active) begin
          tx_line = tx_frame[tx_idx];
          tx_idx++;
          if (tx_idx == DATA_BITS + 2) tx_active = 1'b0;
        end else begin
          tx_line = 1'b1;
        end
      end
    join_none

    // Reset values.
    repeat (2) @(negedge clk_115200hz);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk_115200hz); reset = 1'b0;
    repeat (3) @(negedge clk_115200hz);

    // Latency of frame A5: busy from t0+2, valid at t0+11.
    sb_q.push_back(8'hA5);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 14; i++) begin
      @(negedge clk_115200hz);
      chk($sformatf("lat_busy_%0d", i), busy, (i >= 3 && i <= 11) ? 1'b1 : 1'b0);
      chk($sformatf("lat_valid_%0d", i), valid, (i >= 12) ? 1'b1 : 1'b0);
      chk($sformatf("lat_ferr_%0d", i), frame_err, 1'b0);
      rx_drv = (i < 10) ? fr[i] : 1'b1;
    end
    chk("lat_data", data, 8'hA5);
    ack_pulse();
    chk("lat_ack_valid", valid, 1'b0);
    chk("lat_ack_overrun", overrun, 1'b0);

    // Table of single frames, each acknowledged.
    for (int v = 0; v < 9; v++) begin
      sb_q.push_back(vecs[v].exp_data);
      send_frame(vecs[v].tx_byte, 1'b1);
      repeat (3) @(negedge clk_115200hz);
      chk($sformatf("tbl_data_%0d", v), data, vecs[v].exp_data);
      chk($sformatf("tbl_valid_%0d", v), valid, 1'b1);
      chk($sformatf("tbl_overrun_%0d", v), overrun, 1'b0);
      ack_pulse();
      chk($sformatf("tbl_ack_valid_%0d", v), valid, 1'b0);
    end

    // Back-to-back 3C then FF without ack -> overrun; one ack clears.
    sb_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (3) @(negedge clk_115200hz);
    chk("b2b_data", data, 8'hFF);
    chk("b2b_valid", valid, 1'b1);
    chk("b2b_overrun", overrun, 1'b1);
    ack_pulse();
    chk("b2b_ack_valid", valid, 1'b0);
    chk("b2b_ack_overrun", overrun, 1'b0);
    ack_pulse();
    chk("idle_ack_valid", valid, 1'b0);
    chk("idle_ack_data", data, 8'hFF);

    // Frame 55 with bad stop, line low 5 more cycles, then high.
    fr = {1'b0, 8'h55, 1'b0};
    for (int i = 0; i < 21; i++) begin
      @(negedge clk_115200hz);
      chk($sformatf("brk_busy_%0d", i), busy, (i >= 3 && i <= 17) ? 1'b1 : 1'b0);
      chk($sformatf("brk_ferr_%0d", i), frame_err, (i == 12) ? 1'b1 : 1'b0);
      chk($sformatf("brk_valid_%0d", i), valid, 1'b0);
      chk($sformatf("brk_data_%0d", i), data, 8'hFF);
      rx_drv = (i < 9) ? fr[i] : ((i < 15) ? 1'b0 : 1'b1);
    end
    sb_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    repeat (3) @(negedge clk_115200hz);
    chk("brk_next_data", data, 8'h0F);
    chk("brk_next_valid", valid, 1'b1);
    ack_pulse();

    // Ack coinciding with the completion edge of frame 81.
    sb_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    repeat (3) @(negedge clk_115200hz);
    send_frame(8'h81, 1'b1);
    @(negedge clk_115200hz);
    @(negedge clk_115200hz); ack = 1'b1;
    @(negedge clk_115200hz); ack = 1'b0;
    chk("ackc_data", data, 8'h81);
    chk("ackc_valid", valid, 1'b1);
    chk("ackc_overrun", overrun, 1'b0);
    ack_pulse();
    chk("ackc_clear_valid", valid, 1'b0);

    // Reset after the 4th data bit of C3, then frame 7E.
    @(negedge clk_115200hz); rx_drv = 1'b0;
    fr = {2'b11, 8'hC3};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_115200hz); rx_drv = fr[i];
    end
    @(negedge clk_115200hz); reset = 1'b1; rx_drv = 1'b1;
    #1;
    chk("mrst_data", data, 8'h00);
    chk("mrst_valid", valid, 1'b0);
    chk("mrst_overrun", overrun, 1'b0);
    chk("mrst_frame_err", frame_err, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    @(negedge clk_115200hz); reset = 1'b0;
    repeat (15) @(negedge clk_115200hz);
    chk("mrst_after_valid", valid, 1'b0);
    chk("mrst_after_busy", busy, 1'b0);
    sb_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    repeat (3) @(negedge clk_115200hz);
    chk("mrst_next_data", data, 8'h7E);
    chk("mrst_next_valid", valid, 1'b1);
    ack_pulse();

    // Loopback from the bench transmitter.
    loop_en = 1'b1;
    fr = {2'b00, 8'h00};
    for (int k = 0; k < 3; k++) begin
      logic [7:0] b;
      b = (k == 0) ? 8'h00 : ((k == 1) ? 8'hFF : 8'hA5);
      sb_q.push_back(b);
      tx_q.push_back(b);
      @(negedge clk_115200hz);
      wait_valid($sformatf("loop_wait_%0d", k));
      chk($sformatf("loop_data_%0d", k), data, b);
      ack_pulse();
      repeat (4) @(negedge clk_115200hz);
    end
    loop_en = 1'b0;

    repeat (3) @(negedge clk_115200hz);
    chk("frame_err_pulses", fe_count[7:0], 8'd1);
    chk("sb_leftover", sb_q.size(), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
